fetch_stage: RTL

- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC, issues requests to a variable-latency instruction memory, and applies redirects (taken branch/jump resolved downstream) and hazard stalls.
- Presents instruction, PC+4 and the 2-bit IF/ID control code (0 flush, 1 load, 2 hold) to the IF/ID register.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage, hazard unit and IF/ID register.
package fetch_stage_pkg;

  // IF/ID register control codes.
  localparam logic [1:0] IFID_FLUSH = 2'd0;
  localparam logic [1:0] IFID_LOAD  = 2'd1;
  localparam logic [1:0] IFID_HOLD  = 2'd2;

  // Default PC after reset.
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // StFetch: request outstanding for pc.
  // StHave: instruction buffered while stall blocks delivery.
  // StDiscard: request outstanding but squashed by a redirect.
  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StHave    = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction
// memory, applies redirects and stalls, and feeds the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pcplus4_out,
  output logic [1:0]  ifid_condition
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_pc;

  assign pc_plus4  = pc_q + 32'd4;
  // Targets are word aligned; low bits of the request are ignored.
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      buf_instr_q  <= 32'h0;
      pending_pc_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_instr_q  <= buf_instr_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  // Memory request and IF/ID outputs.
  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    ifid_condition  = IFID_FLUSH;
    instruction_out = 32'h0;
    pcplus4_out     = 32'h0;
    if (!reset) begin
      imem_req = (state_q == StFetch) || (state_q == StDiscard);
      if (redirect) begin
        ifid_condition = IFID_FLUSH;
      end else if (stall) begin
        ifid_condition = IFID_HOLD;
      end else if ((state_q == StFetch && imem_ready) || state_q == StHave) begin
        ifid_condition = IFID_LOAD;
      end
    end
    if (ifid_condition == IFID_LOAD) begin
      instruction_out = (state_q == StHave) ? buf_instr_q : imem_rdata;
      pcplus4_out     = pc_plus4;
    end
  end

  // Next-state logic; redirect takes priority over stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_instr_d  = buf_instr_q;
    pending_pc_d = pending_pc_q;
    unique case (state_q)
      StFetch: begin
        if (redirect && imem_ready) begin
          pc_d = target_pc;
        end else if (redirect) begin
          pending_pc_d = target_pc;
          state_d      = StDiscard;
        end else if (imem_ready && stall) begin
          buf_instr_d = imem_rdata;
          state_d     = StHave;
        end else if (imem_ready) begin
          pc_d = pc_plus4;
        end
      end
      StHave: begin
        if (redirect) begin
          pc_d    = target_pc;
          state_d = StFetch;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = StFetch;
        end
      end
      StDiscard: begin
        if (imem_ready) begin
          // Squashed response is dropped; same-cycle redirect is the newest target.
          pc_d    = redirect ? target_pc : pending_pc_q;
          state_d = StFetch;
        end else if (redirect) begin
          pending_pc_d = target_pc;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

endmodule
